// File: rtl/shift_normalizer.sv
//------------------------------------------------------------------------------
// Module      : shift_normalizer
// Description : Binary-search normalizer; left/right justifies a word, one
//               search step per cycle, reporting the shift distance applied.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_normalizer #(
   parameter int BitWidth = 32
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          Start,
   input  logic                          Left,
   input  logic [BitWidth-1:0]           dIN,
   output logic                          Busy,
   output logic                          Done,
   output logic [BitWidth-1:0]           dOUT,
   output logic [$clog2(BitWidth)-1:0]   ShAmount,
   output logic                          Zero
);

   localparam int ShiftWidth = $clog2(BitWidth);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_nextState;

   logic [BitWidth-1:0]   r_work;
   logic                  r_left;
   logic [ShiftWidth-1:0] r_count;
   logic [ShiftWidth-1:0] r_step;
   logic                  r_done;
   logic [BitWidth-1:0]   r_dOut;
   logic [ShiftWidth-1:0] r_shAmount;
   logic                  r_zero;

   logic                  w_accept;
   logic                  w_finish;
   logic [ShiftWidth-1:0] w_span;
   logic [ShiftWidth-1:0] w_stepBit;
   logic [BitWidth-1:0]   w_topMask;
   logic [BitWidth-1:0]   w_botMask;
   logic                  w_hit;
   logic [BitWidth-1:0]   w_nextWork;
   logic [ShiftWidth-1:0] w_nextCount;

   assign w_accept = Start && ((r_state == IDLE) || (r_state == DONE));
   assign w_finish = (r_state == RUN) && (r_step == '0);

   // Step k examines and moves a span of 2^k bits; the same one-hot value
   // is the count bit recorded when the span turns out to be all zero.
   assign w_span    = ShiftWidth'(1) << r_step;
   assign w_stepBit = ShiftWidth'(1) << r_step;
   assign w_topMask = ~({BitWidth{1'b1}} >> w_span);
   assign w_botMask = ~({BitWidth{1'b1}} << w_span);

   always_comb begin
      w_nextWork  = r_work;
      w_nextCount = r_count;
      w_hit       = 1'b0;
      if (r_left) begin
         w_hit = ((r_work & w_topMask) == '0);
         if (w_hit) begin
            w_nextWork = r_work << w_span;
         end
      end else begin
         w_hit = ((r_work & w_botMask) == '0);
         if (w_hit) begin
            w_nextWork = r_work >> w_span;
         end
      end
      if (w_hit) begin
         w_nextCount = r_count | w_stepBit;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_nextState = RUN;
         RUN:     if (r_step == '0) w_nextState = DONE;
         DONE:    if (w_accept) w_nextState = RUN;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_work     <= '0;
         r_left     <= 1'b0;
         r_count    <= '0;
         r_step     <= '0;
         r_done     <= 1'b0;
         r_dOut     <= '0;
         r_shAmount <= '0;
         r_zero     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_work  <= dIN;
            r_left  <= Left;
            r_count <= '0;
            r_step  <= ShiftWidth'(ShiftWidth - 1);
         end else if (r_state == RUN) begin
            r_work  <= w_nextWork;
            r_count <= w_nextCount;
            if (r_step != '0) begin
               r_step <= r_step - ShiftWidth'(1);
            end
         end
         r_done <= w_finish;
         // Shifts only ever discard zero bits, so an all-zero result means
         // the captured word was all zero.
         if (w_finish) begin
            r_dOut     <= w_nextWork;
            r_shAmount <= w_nextCount;
            r_zero     <= (w_nextWork == '0);
         end
      end
   end

   assign Busy     = (r_state == RUN);
   assign Done     = r_done;
   assign dOUT     = r_dOut;
   assign ShAmount = r_shAmount;
   assign Zero     = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_shift_normalizer.sv
// Bench for shift_normalizer at BitWidth=8: scoreboard of expected results
// built from an independent shift-until-justified model.
`default_nettype none

module tb_shift_normalizer;

   logic       Clk;
   logic       Reset;
   logic       Start;
   logic       Left;
   logic [7:0] dIN;
   logic       Busy;
   logic       Done;
   logic [7:0] dOUT;
   logic [2:0] ShAmount;
   logic       Zero;

   typedef struct packed {
      logic [7:0] dOut;
      logic [2:0] sh;
      logic       zero;
   } exp_t;

   exp_t q[$];
   int   nChecks = 0;
   int   nFails  = 0;

   shift_normalizer #(.BitWidth(8)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Start    (Start),
      .Left     (Left),
      .dIN      (dIN),
      .Busy     (Busy),
      .Done     (Done),
      .dOUT     (dOUT),
      .ShAmount (ShAmount),
      .Zero     (Zero)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   function automatic exp_t model(input logic [7:0] d, input logic left);
      exp_t       e;
      logic [7:0] v;
      int         n;
      v = d;
      n = 0;
      if (d == 8'h00) begin
         e.dOut = 8'h00;
         e.sh   = 3'd7;
         e.zero = 1'b1;
      end else begin
         if (left) begin
            while (v[7] == 1'b0) begin v = v << 1; n++; end
         end else begin
            while (v[0] == 1'b0) begin v = v >> 1; n++; end
         end
         e.dOut = v;
         e.sh   = 3'(n);
         e.zero = 1'b0;
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Drives one accepted Start; returns one step into the operation (cycle t+1).
   task automatic issue(input logic [7:0] d, input logic left);
      Start = 1'b1;
      dIN   = d;
      Left  = left;
      q.push_back(model(d, left));
      tick();
      Start = 1'b0;
      dIN   = 8'hA5;
   endtask

   // Bounded wait for Done; cyc is the cycle index relative to acceptance.
   task automatic await_done(output int cyc);
      cyc = 1;
      while (Done !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      exp_t e;
      int   cyc;
      Reset = 1'b1;
      Start = 1'b1;
      dIN   = 8'hFF;
      Left  = 1'b1;
      tick();
      tick();
      nChecks++;
      if ({Busy, Done, dOUT, ShAmount, Zero} !== 14'd0) begin
         nFails++;
         $display("FAIL reset_outputs got busy=%b done=%b dout=%h sh=%0d zero=%b want all 0",
                  Busy, Done, dOUT, ShAmount, Zero);
      end
      Reset = 1'b0;
      issue(8'h40, 1'b1);
      nChecks++;
      if (Busy !== 1'b1) begin
         nFails++;
         $display("FAIL start_after_reset busy got %b want 1", Busy);
      end
      await_done(cyc);
      nChecks++;
      if (cyc != 4) begin
         nFails++;
         $display("FAIL start_after_reset_latency got %0d want 4", cyc);
      end
      e = q.pop_front();
      nChecks++;
      if ({dOUT, ShAmount, Zero} !== {e.dOut, e.sh, e.zero}) begin
         nFails++;
         $display("FAIL start_after_reset_result got %h/%0d/%b want %h/%0d/%b",
                  dOUT, ShAmount, Zero, e.dOut, e.sh, e.zero);
      end
   endtask

   task automatic test_left_latency();
      exp_t e;
      issue(8'h16, 1'b1);
      for (int c = 1; c <= 3; c++) begin
         nChecks++;
         if (Busy !== 1'b1 || Done !== 1'b0) begin
            nFails++;
            $display("FAIL left_run_cycle%0d got busy=%b done=%b want 1/0", c, Busy, Done);
         end
         tick();
      end
      nChecks++;
      if (Busy !== 1'b0 || Done !== 1'b1) begin
         nFails++;
         $display("FAIL left_done_cycle got busy=%b done=%b want 0/1", Busy, Done);
      end
      e = q.pop_front();
      nChecks++;
      if ({dOUT, ShAmount, Zero} !== {e.dOut, e.sh, e.zero}) begin
         nFails++;
         $display("FAIL left_result got %h/%0d/%b want %h/%0d/%b",
                  dOUT, ShAmount, Zero, e.dOut, e.sh, e.zero);
      end
      tick();
      tick();
      nChecks++;
      if (Done !== 1'b0 || {dOUT, ShAmount, Zero} !== {e.dOut, e.sh, e.zero}) begin
         nFails++;
         $display("FAIL done_hold got done=%b %h/%0d/%b want 0 %h/%0d/%b",
                  Done, dOUT, ShAmount, Zero, e.dOut, e.sh, e.zero);
      end
   endtask

   // Single operations, each checked for latency and result.
   task automatic test_patterns();
      logic [7:0] pd [6] = '{8'h16, 8'h00, 8'h00, 8'h80, 8'h01, 8'h0C};
      logic       pl [6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
      exp_t e;
      int   cyc;
      for (int i = 0; i < 6; i++) begin
         issue(pd[i], pl[i]);
         await_done(cyc);
         nChecks++;
         if (cyc != 4) begin
            nFails++;
            $display("FAIL pattern%0d_latency got %0d want 4", i, cyc);
         end
         e = q.pop_front();
         nChecks++;
         if ({dOUT, ShAmount, Zero} !== {e.dOut, e.sh, e.zero}) begin
            nFails++;
            $display("FAIL pattern%0d_result din=%h left=%b got %h/%0d/%b want %h/%0d/%b",
                     i, pd[i], pl[i], dOUT, ShAmount, Zero, e.dOut, e.sh, e.zero);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   cyc;
      issue(8'h16, 1'b1);
      Start = 1'b1;
      dIN   = 8'hFF;
      Left  = 1'b0;
      tick();
      tick();
      tick();
      nChecks++;
      if (Done !== 1'b1) begin
         nFails++;
         $display("FAIL b2b_first_done got %b want 1", Done);
      end
      e = q.pop_front();
      nChecks++;
      if ({dOUT, ShAmount, Zero} !== {e.dOut, e.sh, e.zero}) begin
         nFails++;
         $display("FAIL b2b_first_result got %h/%0d/%b want %h/%0d/%b",
                  dOUT, ShAmount, Zero, e.dOut, e.sh, e.zero);
      end
      issue(8'h01, 1'b1);
      nChecks++;
      if (Busy !== 1'b1 || Done !== 1'b0 || {dOUT, ShAmount} !== {e.dOut, e.sh}) begin
         nFails++;
         $display("FAIL b2b_no_gap got busy=%b done=%b %h/%0d want 1/0 %h/%0d",
                  Busy, Done, dOUT, ShAmount, e.dOut, e.sh);
      end
      await_done(cyc);
      nChecks++;
      if (cyc != 4) begin
         nFails++;
         $display("FAIL b2b_second_latency got %0d want 4", cyc);
      end
      e = q.pop_front();
      nChecks++;
      if ({dOUT, ShAmount, Zero} !== {e.dOut, e.sh, e.zero}) begin
         nFails++;
         $display("FAIL b2b_second_result got %h/%0d/%b want %h/%0d/%b",
                  dOUT, ShAmount, Zero, e.dOut, e.sh, e.zero);
      end
   endtask

   task automatic test_reset_midrun();
      exp_t e;
      int   cyc;
      issue(8'h5A, 1'b1);
      void'(q.pop_back());
      tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      nChecks++;
      if ({Busy, Done, dOUT, ShAmount, Zero} !== 14'd0) begin
         nFails++;
         $display("FAIL midrun_reset got busy=%b done=%b dout=%h sh=%0d zero=%b want all 0",
                  Busy, Done, dOUT, ShAmount, Zero);
      end
      issue(8'h01, 1'b0);
      await_done(cyc);
      nChecks++;
      if (cyc != 4) begin
         nFails++;
         $display("FAIL midrun_restart_latency got %0d want 4", cyc);
      end
      e = q.pop_front();
      nChecks++;
      if ({dOUT, ShAmount, Zero} !== {e.dOut, e.sh, e.zero}) begin
         nFails++;
         $display("FAIL midrun_restart_result got %h/%0d/%b want %h/%0d/%b",
                  dOUT, ShAmount, Zero, e.dOut, e.sh, e.zero);
      end
   endtask

   task automatic test_random();
      exp_t e;
      int   cyc;
      for (int i = 0; i < 24; i++) begin
         issue(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         await_done(cyc);
         e = q.pop_front();
         nChecks++;
         if (cyc != 4 || {dOUT, ShAmount, Zero} !== {e.dOut, e.sh, e.zero}) begin
            nFails++;
            $display("FAIL random%0d got lat=%0d %h/%0d/%b want lat=4 %h/%0d/%b",
                     i, cyc, dOUT, ShAmount, Zero, e.dOut, e.sh, e.zero);
         end
         for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      end
   endtask

   initial begin
      Reset = 1'b1;
      Start = 1'b0;
      Left  = 1'b0;
      dIN   = 8'h00;
      test_reset();
      tick();
      test_left_latency();
      test_patterns();
      test_back_to_back();
      tick();
      test_reset_midrun();
      tick();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout simulation exceeded time limit");
      $fatal(1);
   end

endmodule

`default_nettype wire
